// File: rtl/rr_arbiter_fsm_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and default sizing.
package rr_arbiter_fsm_pkg;

    localparam int DEFAULT_N        = 4;
    localparam int DEFAULT_MAX_HOLD = 8;
    localparam int HOLD_W           = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_fsm_rr_pick.sv
// Combinational round-robin search: first set request after 'last', wrapping,
// optionally ignoring the requester at 'last' itself.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic          exclude_en,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0]  masked;
    logic [IW-1:0] cand;

    always_comb begin
        masked = req;
        if (exclude_en) begin
            masked[last] = 1'b0;
        end
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last) + i) % N);
            if (!found && masked[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// Two-state round-robin arbiter with a per-owner hold limit; outputs are
// decoded purely from registered state so they never follow req combinationally.
module rr_arbiter_fsm
    import rr_arbiter_fsm_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    // The count is taken before the current cycle is added, so an owner reaches
    // its limit during its MAX_HOLD-th granted cycle and rotates on that edge.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);

    state_t            state, state_nxt;
    logic [IW-1:0]     owner, owner_nxt;
    logic [IW-1:0]     last, last_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic              exclude_en;

    assign exclude_en = (state == GRANT);

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req        (req),
        .last       (last),
        .exclude_en (exclude_en),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            last     <= IW'(N - 1);
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = GRANT;
                    owner_nxt = pick_idx;
                    last_nxt  = pick_idx;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (!req[owner] || (hold_cnt >= HOLD_LAST && pick_found)) begin
                    if (pick_found) begin
                        owner_nxt = pick_idx;
                        last_nxt  = pick_idx;
                        hold_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                        hold_nxt  = '0;
                    end
                end else if (hold_cnt < HOLD_MAX) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        busy   = (state == GRANT);
        gnt    = '0;
        gnt_id = '0;
        if (busy) begin
            gnt[owner] = 1'b1;
            gnt_id     = owner;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Directed and randomized checks for rr_arbiter_fsm with N=4, MAX_HOLD=8.
module tb_rr_arbiter_fsm;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req   = '0;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rr_arbiter_fsm #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req   = '0;
        rst_n = 1'b0;
        #3;
        tests_run++;
        if (gnt !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_gnt: got %b expected %b", gnt, 4'b0000);
        end
        tests_run++;
        if (gnt_id !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_gnt_id: got %0d expected %0d", gnt_id, 0);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b expected %b", busy, 1'b0);
        end
        req = 4'b1111;
        tick();
        tests_run++;
        if (gnt !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_held_gnt: got %b expected %b", gnt, 4'b0000);
        end
        rst_n = 1'b1;
        req   = '0;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle_busy: got %b expected %b", busy, 1'b0);
        end
    endtask

    task automatic test_single_req();
        do_reset();
        tick();
        req = 4'b0100;
        #1;
        tests_run++;
        if (gnt !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL single_pre_edge: got %b expected %b", gnt, 4'b0000);
        end
        tick();
        tests_run++;
        if (gnt !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL single_gnt: got %b expected %b", gnt, 4'b0100);
        end
        tests_run++;
        if (gnt_id !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL single_gnt_id: got %0d expected %0d", gnt_id, 2);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_busy: got %b expected %b", busy, 1'b1);
        end
        req = '0;
        tick();
        tests_run++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_release: got gnt=%b busy=%b expected gnt=0000 busy=0", gnt, busy);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_gnt;
        logic [1:0] exp_id;
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            tick();
            exp_id  = 2'((c / 8) % 4);
            exp_gnt = 4'b0001 << exp_id;
            tests_run++;
            if (gnt !== exp_gnt || gnt_id !== exp_id) begin
                tests_failed++;
                $display("[TB] FAIL rotation_cycle%0d: got gnt=%b id=%0d expected gnt=%b id=%0d",
                         c, gnt, gnt_id, exp_gnt, exp_id);
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_handoff();
        do_reset();
        req = 4'b0010;
        tick();
        tests_run++;
        if (gnt !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL handoff_first: got %b expected %b", gnt, 4'b0010);
        end
        req = 4'b1001;
        tick();
        tests_run++;
        if (gnt !== 4'b1000 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL handoff_switch: got gnt=%b busy=%b expected gnt=1000 busy=1", gnt, busy);
        end
        req = 4'b0000;
        tick();
        tests_run++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL handoff_idle: got gnt=%b busy=%b expected gnt=0000 busy=0", gnt, busy);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            tick();
            tests_run++;
            if (gnt !== 4'b0010) begin
                tests_failed++;
                $display("[TB] FAIL saturation_cycle%0d: got %b expected %b", c, gnt, 4'b0010);
            end
        end
        req = 4'b1010;
        tick();
        tests_run++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            tests_failed++;
            $display("[TB] FAIL saturation_rotate: got gnt=%b id=%0d expected gnt=1000 id=3", gnt, gnt_id);
        end
        req = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0011;
        tick();
        tests_run++;
        if (gnt !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: got %b expected %b", gnt, 4'b0001);
        end
        req = 4'b0010;
        tick();
        tests_run++;
        if (gnt !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL b2b_to1: got %b expected %b", gnt, 4'b0010);
        end
        req = 4'b0011;
        tick();
        tests_run++;
        if (gnt !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL b2b_hold1: got %b expected %b", gnt, 4'b0010);
        end
        req = 4'b0001;
        tick();
        tests_run++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_back0: got gnt=%b id=%0d expected gnt=0001 id=0", gnt, gnt_id);
        end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0100;
        tick();
        tests_run++;
        if (gnt !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL midrst_pre: got %b expected %b", gnt, 4'b0100);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_async: got gnt=%b busy=%b id=%0d expected gnt=0000 busy=0 id=0",
                     gnt, busy, gnt_id);
        end
        req = 4'b0101;
        tick();
        tests_run++;
        if (gnt !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL midrst_held: got %b expected %b", gnt, 4'b0000);
        end
        rst_n = 1'b1;
        #2;
        tests_run++;
        if (gnt !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL midrst_release: got %b expected %b", gnt, 4'b0000);
        end
        tick();
        tests_run++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_first: got gnt=%b id=%0d expected gnt=0001 id=0", gnt, gnt_id);
        end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        int           waitc [N];
        logic [N-1:0] prev_req;
        logic         prev_busy;
        logic         starved;
        do_reset();
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            prev_req  = req;
            prev_busy = busy;
            tick();
            tests_run++;
            if (!$onehot0(gnt)) begin
                tests_failed++;
                $display("[TB] FAIL random_onehot cyc%0d: got %b expected at most one bit", cyc, gnt);
            end
            tests_run++;
            if ((gnt & ~prev_req) !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL random_unrequested cyc%0d: got gnt=%b expected subset of req=%b",
                         cyc, gnt, prev_req);
            end
            tests_run++;
            if (!prev_busy && prev_req != 0 && busy !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL random_latency cyc%0d: got busy=%b expected 1", cyc, busy);
            end
            starved = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (prev_req[i] && !gnt[i]) waitc[i]++;
                else waitc[i] = 0;
                if (waitc[i] > (N - 1) * MAX_HOLD + 1) starved = 1'b1;
            end
            tests_run++;
            if (starved) begin
                tests_failed++;
                $display("[TB] FAIL random_starvation cyc%0d: got waits %0d/%0d/%0d/%0d expected <= %0d",
                         cyc, waitc[0], waitc[1], waitc[2], waitc[3], (N - 1) * MAX_HOLD + 1);
            end
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (gnt[i] && $urandom_range(2) == 0) req[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                end
            end
        end
        req = '0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_req();
        test_rotation();
        test_handoff();
        test_saturation();
        test_back_to_back();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_fsm.md
RR_ARBITER_FSM -- requirements
Module: rr_arbiter_fsm

Interface
REQ-001 The block SHALL have parameter N, default 4, which sets the number of requesters (2..8).
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, which sets the maximum number of consecutive granted cycles while others wait (1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, N bits: one request line per requester, level-sensitive, sampled at posedge clk.
REQ-006 The block SHALL have port gnt, output, N bits: one-hot grant, or all-zero when idle.
REQ-007 The block SHALL have port gnt_id, output, clog2(N) bits: index of the current owner; 0 when idle.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever any grant is active.

Function
REQ-009 The block SHALL be a Moore machine: gnt, gnt_id and busy SHALL be decoded only from registered state (state, owner), never directly from req.
REQ-010 The FSM SHALL have two states: IDLE (no grant) and GRANT (owner holds the resource).
REQ-011 In IDLE with req == 0, the FSM SHALL remain in IDLE.
REQ-012 In IDLE with any req bit set at edge k, the FSM SHALL enter GRANT; gnt is visible in cycle k+1 (1-cycle latency).
REQ-013 Owner selection SHALL be round-robin: search starts at last+1 mod N and wraps; the first set req bit wins; last is the most recently granted index.
REQ-014 In GRANT, while req[owner] stays high and the hold limit is not reached, owner SHALL be unchanged.
REQ-015 In GRANT, when req[owner] is sampled low and other req bits are set, the block SHALL switch to the RR-selected next owner on the same edge, with no idle bubble.
REQ-016 In GRANT, when req[owner] is sampled low and no other req bit is set, the FSM SHALL go to IDLE.
REQ-017 The block SHALL keep a hold counter: it clears on each new grant (owner change or IDLE->GRANT), then increments each granted cycle and saturates at MAX_HOLD.
REQ-018 When the hold counter equals MAX_HOLD and any other req bit is set, the block SHALL force a rotation to the RR-selected next owner, even if req[owner] is still high.
REQ-019 When the hold counter equals MAX_HOLD and no other request is pending, the owner SHALL keep the grant; the counter stays saturated.
REQ-020 The owner's own req bit SHALL be excluded from the next-owner search on release or forced rotation; the owner is re-eligible only after another requester is served or the FSM returns to IDLE.
REQ-021 gnt SHALL never have more than one bit set in any cycle.
REQ-022 last SHALL update to owner on every grant; it SHALL NOT change in IDLE.

Reset
REQ-023 Asserting rst_n low SHALL immediately force state=IDLE, gnt=0, gnt_id=0, busy=0, hold counter=0 and last=N-1, so requester 0 has first priority.
REQ-024 Reset asserted during GRANT SHALL drop the grant asynchronously; no grant SHALL be issued until the first posedge after rst_n deasserts.
REQ-025 Release of rst_n SHALL be treated as synchronous to clk.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE=1'b0, GRANT=1'b1) and the default N and MAX_HOLD constants.
REQ-027 Round-robin selection SHALL be one combinational sub-module, rr_pick, taking (req, last, exclude_en) and returning (found, idx).
REQ-028 Implementation SHALL use one sequential always block (state, owner, last, counter) plus combinational next-state and output blocks.

Verification
REQ-029 Scenario: req=4'b0100 applied one cycle after reset -> gnt=4'b0100 and gnt_id=2 in the next cycle; busy=1.
REQ-030 Scenario: req=4'b1111 held constant, MAX_HOLD=8 -> grants rotate 0,1,2,3,0..., each lasting exactly 8 cycles; gnt stays one-hot throughout.
REQ-031 Scenario: owner 1 drops req while req=4'b1001 -> next cycle gnt=4'b1000 with no idle cycle; then 3 drops with no others pending -> IDLE, gnt=0.
REQ-032 Scenario: req=4'b0010 held for 20 cycles alone -> gnt=4'b0010 for all 20 cycles (saturation, REQ-019); req[3] raised at cycle 20 -> grant moves to 3 at the next edge.
REQ-033 Scenario: rst_n pulsed low mid-grant (owner 2) -> gnt=0 immediately; after release with req=4'b0101 -> requester 0 is granted first.
REQ-034 Scenario: random req traffic for 10k cycles -> checker confirms one-hot gnt, 1-cycle grant latency from IDLE, no starvation (wait <= (N-1)*MAX_HOLD+1 cycles).
